// File: rtl/pl_trap_if.sv
// Trap sequencer bundle: interrupt/CSR/MEM-stage inputs and the flush/redirect/CSR strobes.
// Latency: none, wires only.
// Backpressure: none; fpu_busy is the only hold-off and stall_pipe the only freeze.
interface pl_trap_if;
    logic        irq_ext;
    logic        csr_mie;
    logic        csr_meie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        is_mret_mem;
    logic        mem_csr_en;
    logic [31:0] resume_pc;
    logic        fpu_busy;
    logic        stall_pipe;
    logic        flush_fde;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        mepc_we;
    logic [31:0] mepc_wdata;
    logic        mcause_we;
    logic [31:0] mcause_wdata;
    logic        mie_clr;
    logic        mie_set;
    logic        in_trap;
    logic        drain_timeout;

    // Sequencer side: consumes pipeline/CSR state, drives the strobes.
    modport master (
        input  irq_ext, csr_mie, csr_meie, csr_mtvec, csr_mepc,
               is_mret_mem, mem_csr_en, resume_pc, fpu_busy,
        output stall_pipe, flush_fde, pc_redirect, redirect_pc, mepc_we, mepc_wdata,
               mcause_we, mcause_wdata, mie_clr, mie_set, in_trap, drain_timeout
    );

    // Pipeline/CSR side.
    modport slave (
        output irq_ext, csr_mie, csr_meie, csr_mtvec, csr_mepc,
               is_mret_mem, mem_csr_en, resume_pc, fpu_busy,
        input  stall_pipe, flush_fde, pc_redirect, redirect_pc, mepc_we, mepc_wdata,
               mcause_we, mcause_wdata, mie_clr, mie_set, in_trap, drain_timeout
    );
endinterface

// File: rtl/pl_trap_ctrl.sv
// Pipeline trap sequencer: takes ext irq / MRET, drains FPU, issues flush+redirect+CSR strobes.
// Latency: irq sampled in IDLE at edge N -> TRAP strobes during cycle N+1, GUARD N+2.
// Backpressure: in-flight FPU op holds the sequence in DRAIN with stall_pipe high.
module pl_trap_ctrl #(
    parameter int unsigned DRAIN_MAX = 16,
    parameter logic [31:0] CAUSE_EXT = 32'h8000_000B
) (
    input  logic       clk,
    input  logic       clrn,
    pl_trap_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        TRAP  = 3'd2,
        RET   = 3'd3,
        GUARD = 3'd4
    } state_t;

    localparam logic [7:0] CNT_SAT  = 8'(DRAIN_MAX);
    localparam logic [7:0] CNT_LAST = 8'(DRAIN_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] mepc_wdata_q, mepc_wdata_d;
    logic        irq_take;

    assign irq_take = bus.irq_ext & bus.csr_mie & bus.csr_meie;

    // State, drain counter, sticky timeout and captured trap pc.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            timeout_q    <= 1'b0;
            mepc_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            mepc_wdata_q <= mepc_wdata_d;
        end
    end

    // Next-state: MRET beats irq; a CSR op in MEM delays the irq by one cycle so it commits.
    always_comb begin
        state_d      = state_q;
        cnt_d        = 8'd0;
        timeout_d    = timeout_q;
        mepc_wdata_d = mepc_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.is_mret_mem) begin
                    state_d = RET;
                end else if (irq_take && bus.mem_csr_en) begin
                    state_d = IDLE;
                end else if (irq_take && bus.fpu_busy) begin
                    state_d = DRAIN;
                end else if (irq_take) begin
                    state_d      = TRAP;
                    mepc_wdata_d = bus.resume_pc;
                end
            end
            DRAIN: begin
                if (!irq_take) begin
                    state_d = IDLE;
                end else if (!bus.fpu_busy) begin
                    state_d      = TRAP;
                    mepc_wdata_d = bus.resume_pc;
                end else begin
                    // Keep waiting after timeout; the flag only reports a stuck FPU.
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            TRAP:    state_d = GUARD;
            RET:     state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode; redirect/cause values are zero outside the states that use them.
    always_comb begin
        bus.stall_pipe    = 1'b0;
        bus.flush_fde     = 1'b0;
        bus.pc_redirect   = 1'b0;
        bus.redirect_pc   = 32'd0;
        bus.mepc_we       = 1'b0;
        bus.mcause_we     = 1'b0;
        bus.mcause_wdata  = 32'd0;
        bus.mie_clr       = 1'b0;
        bus.mie_set       = 1'b0;
        bus.in_trap       = (state_q != IDLE);
        bus.mepc_wdata    = mepc_wdata_q;
        bus.drain_timeout = timeout_q;
        unique case (state_q)
            DRAIN: bus.stall_pipe = 1'b1;
            TRAP: begin
                bus.flush_fde    = 1'b1;
                bus.pc_redirect  = 1'b1;
                bus.redirect_pc  = {bus.csr_mtvec[31:2], 2'b00};
                bus.mepc_we      = 1'b1;
                bus.mcause_we    = 1'b1;
                bus.mcause_wdata = CAUSE_EXT;
                bus.mie_clr      = 1'b1;
            end
            RET: begin
                bus.flush_fde   = 1'b1;
                bus.pc_redirect = 1'b1;
                bus.redirect_pc = bus.csr_mepc;
                bus.mie_set     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
